shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and load sequencer for a shared parallel-load register, with optional burst lock.
// Optional: define SHARED_REG_ARB_PRIO_EN to give requester 0 absolute priority when idle.
module shared_reg_arbiter #(
  parameter int unsigned      width       = 8,
  parameter int unsigned      num_req     = 4,
  parameter logic [width-1:0] reset_value = '0,
  parameter int unsigned      max_burst   = 4
) (
  input  logic                     clk,
  input  logic                     reset_N,
  input  logic [num_req-1:0]       req,
  input  logic [num_req-1:0]       lock,
  input  logic [num_req*width-1:0] d_bus,
  output logic [num_req-1:0]       ack,
  output logic [width-1:0]         q,
  output logic [2:0]               q_owner,
  output logic                     busy
);

  localparam int unsigned max_req = 8;

  typedef enum logic {IDLE, BURST} state_t;
  typedef logic [num_req-1:0] req_vec_t;

  if (num_req < 2 || num_req > max_req || max_burst == 0 || max_burst > 15) begin : g_cfg_err
    $error("shared_reg_arbiter: illegal configuration num_req=%0d max_burst=%0d", num_req, max_burst);
  end

  state_t                state;
  logic [2:0]            ptr;
  logic [3:0]            cnt;
  logic [max_req-1:0]    req_ext;
  logic [max_req-1:0]    lock_ext;
  logic [width-1:0]      d_arr [max_req];
  logic                  any_c;
  logic [2:0]            win_c;
  logic [2:0]            nxt_ptr_c;
  int unsigned           scan_idx;

  assign req_ext  = 8'(req);
  assign lock_ext = 8'(lock);

  // Pad the data slices out to eight entries so a 3-bit owner index selects directly.
  for (genvar gi = 0; gi < max_req; gi++) begin : g_slice
    if (gi < num_req) begin : g_used
      assign d_arr[gi] = d_bus[gi*width +: width];
    end else begin : g_pad
      assign d_arr[gi] = '0;
    end
  end

  // Winner search: first active request at or after the pointer, wrapping at num_req.
  always_comb begin
    any_c     = 1'b0;
    win_c     = '0;
    scan_idx  = 0;
    nxt_ptr_c = ptr;
    for (int unsigned k = 0; k < num_req; k++) begin
      scan_idx = (32'(ptr) + k) % num_req;
      if (!any_c && req_ext[3'(scan_idx)]) begin
        any_c = 1'b1;
        win_c = 3'(scan_idx);
      end
    end
    if (any_c) begin
      nxt_ptr_c = 3'((32'(win_c) + 32'd1) % num_req);
    end
`ifdef SHARED_REG_ARB_PRIO_EN
    if (req_ext[0]) begin
      any_c     = 1'b1;
      win_c     = '0;
      nxt_ptr_c = ptr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      q       <= reset_value;
      q_owner <= '0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any_c) begin
            q       <= d_arr[win_c];
            q_owner <= win_c;
            ack     <= req_vec_t'(8'd1 << win_c);
            ptr     <= nxt_ptr_c;
            if (lock_ext[win_c] && max_burst > 1) begin
              state <= BURST;
              busy  <= 1'b1;
              cnt   <= 4'd1;
            end
          end
        end
        BURST: begin
          // Owner keeps loading while it holds req; dropping lock makes this the last load.
          if (req_ext[q_owner]) begin
            q   <= d_arr[q_owner];
            ack <= req_vec_t'(8'd1 << q_owner);
            cnt <= cnt + 4'd1;
            if (!lock_ext[q_owner] || (cnt + 4'd1 == 4'(max_burst))) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random traffic against a reference model.
module tb_shared_reg_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned MB = 4;
  localparam logic [7:0]  RV = 8'h5A;

  logic           clk = 1'b0;
  logic           reset_N;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] d_bus;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [2:0]     q_owner;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // Reference model: plain bookkeeping of who owns the register and how many loads the burst has used.
  logic [7:0] m_q;
  logic [3:0] m_ack;
  int         m_owner;
  int         m_ptr;
  bit         m_in_burst;
  int         m_loads;

  shared_reg_arbiter #(.width(W), .num_req(N), .reset_value(RV), .max_burst(MB)) dut (
    .clk(clk), .reset_N(reset_N), .req(req), .lock(lock), .d_bus(d_bus),
    .ack(ack), .q(q), .q_owner(q_owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
    int w;
    if (!rst_n) begin
      m_q = RV; m_ack = '0; m_owner = 0; m_ptr = 0; m_in_burst = 0; m_loads = 0;
      return;
    end
    m_ack = '0;
    if (!m_in_burst) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`ifdef SHARED_REG_ARB_PRIO_EN
      if (r[0]) w = 0;
`endif
      if (w >= 0) begin
        m_q = d[w*8 +: 8];
        m_owner = w;
        m_ack[w] = 1'b1;
`ifdef SHARED_REG_ARB_PRIO_EN
        if (w != 0) m_ptr = (w + 1) % N;
`else
        m_ptr = (w + 1) % N;
`endif
        if (l[w] && MB > 1) begin m_in_burst = 1; m_loads = 1; end
      end
    end else if (r[m_owner]) begin
      m_q = d[m_owner*8 +: 8];
      m_ack[m_owner] = 1'b1;
      m_loads++;
      if (!l[m_owner] || m_loads == MB) m_in_burst = 0;
    end else begin
      m_in_burst = 0;
    end
  endtask

  // Apply inputs, clock one edge, advance the model, then check all outputs 1 time unit later.
  task automatic step(input logic rst_n, input logic [3:0] r, input logic [3:0] l, input string tag);
    reset_N = rst_n; req = r; lock = l;
    @(posedge clk);
    model_edge(rst_n, r, l, d_bus);
    #1;
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".owner"}, 32'(q_owner), 32'(m_owner));
    chk({tag, ".ack"}, 32'(ack), 32'(m_ack));
    chk({tag, ".busy"}, 32'(busy), 32'(m_in_burst));
  endtask

  initial begin
    reset_N = 1'b0; req = '0; lock = '0;
    d_bus = {8'h13, 8'h12, 8'h11, 8'h10};

    step(1'b0, 4'b0000, 4'b0000, "reset");
    chk("reset.q_const", 32'(q), 32'h5A);
    chk("reset.ack_const", 32'(ack), 32'h0);

`ifndef SHARED_REG_ARB_PRIO_EN
    // Round robin over four always-requesting ports.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 4'b0000, "rr");
      chk("rr.q_const", 32'(q), 32'h10 + 32'(i % 4));
      chk("rr.ack_const", 32'(ack), 32'(1) << (i % 4));
    end
    step(1'b1, 4'b0000, 4'b0000, "rr.idle");

    // Park the pointer at 3, then requests 0 and 2 wrap around.
    step(1'b1, 4'b0100, 4'b0000, "wrap.set");
    step(1'b1, 4'b0101, 4'b0000, "wrap.a");
    chk("wrap.first", 32'(q_owner), 32'd0);
    step(1'b1, 4'b0101, 4'b0000, "wrap.b");
    chk("wrap.second", 32'(q_owner), 32'd2);
    step(1'b1, 4'b1001, 4'b0000, "wrap.ptr");
    chk("wrap.ptr_at3", 32'(q_owner), 32'd3);

    // Burst limit: requester 1 locks for max_burst loads, then requester 2.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0110, 4'b0010, "burst");
      chk("burst.owner_const", 32'(q_owner), (i < 4) ? 32'd1 : 32'd2);
    end
    step(1'b1, 4'b0000, 4'b0000, "burst.idle");

    // Early exit: lock dropped after the second load still yields a third load.
    step(1'b1, 4'b0010, 4'b0010, "early.1");
    step(1'b1, 4'b0010, 4'b0010, "early.2");
    chk("early.busy2", 32'(busy), 32'd1);
    step(1'b1, 4'b0010, 4'b0000, "early.3");
    chk("early.owner3", 32'(q_owner), 32'd1);
    chk("early.busy3", 32'(busy), 32'd0);
    step(1'b1, 4'b1010, 4'b0000, "early.rr");
    chk("early.resume", 32'(q_owner), 32'd3);
`else
    // Requester 0 wins every idle cycle; without it the pointer alternates 1 and 3.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1011, 4'b0000, "prio");
      chk("prio.owner0", 32'(q_owner), 32'd0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1010, 4'b0000, "prio.rr");
`endif

    // Reset in the middle of a burst aborts it with no ack.
    step(1'b1, 4'b0001, 4'b0001, "rstb.1");
    step(1'b1, 4'b0001, 4'b0001, "rstb.2");
    step(1'b0, 4'b0001, 4'b0001, "rstb.rst");
    chk("rstb.ack_const", 32'(ack), 32'h0);
    chk("rstb.busy_const", 32'(busy), 32'h0);
    chk("rstb.q_const", 32'(q), 32'h5A);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r, l;
      d_bus = $urandom;
      r = 4'($urandom);
      l = 4'($urandom) | 4'($urandom);
      step(($urandom_range(0, 49) != 0), r, l, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
